// File: rtl/pc_seq.sv
// Program-counter sequencer and fetch controller for the 16-bit core.
// It steps the PC, applies taken jumps with a fixed flush window, holds on stalls and halts on OP_END.
module pc_seq #(
    parameter int                PC_W      = 12,
    parameter logic [PC_W-1:0]   START_ADR = '0,
    parameter int                FLUSH_CYC = 2
) (
    input  logic            clk_i,
    input  logic            rst,
    input  logic            start_i,
    input  logic            stall_i,
    input  logic            jmp_i,
    input  logic            jn_i,
    input  logic            jr_i,
    input  logic            cond_i,
    input  logic [PC_W-1:0] tgt_i,
    input  logic            end_i,
    output logic [PC_W-1:0] imem_adr_o,
    output logic            imem_rd_o,
    output logic            instr_vld_o,
    output logic            flush_o,
    output logic            halt_o,
    output logic            busy_o,
    output logic [7:0]      jmp_cnt_o
);

    // state   | meaning
    // S_IDLE  | waiting for start_i, no fetch
    // S_RUN   | fetching sequentially, accepting redirects
    // S_FLUSH | bubble window after a taken jump
    // S_HALT  | program ended, only rst leaves
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_HALT} state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYC);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [2:0]      fcnt_q, fcnt_d;
    logic            vld_q, vld_d;
    logic [7:0]      jcnt_q, jcnt_d;
    logic            taken;

    assign taken = jmp_i | ((jn_i | jr_i) & cond_i);

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= START_ADR;
            fcnt_q  <= '0;
            vld_q   <= 1'b0;
            jcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fcnt_q  <= fcnt_d;
            vld_q   <= vld_d;
            jcnt_q  <= jcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fcnt_d    = fcnt_q;
        vld_d     = vld_q;
        jcnt_d    = jcnt_q;
        imem_rd_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                vld_d = 1'b0;
                if (start_i) state_d = S_RUN;
            end
            S_RUN: begin
                imem_rd_o = !stall_i;
                if (end_i) begin
                    state_d = S_HALT;
                    vld_d   = 1'b0;
                end else if (stall_i) begin
                    // hold everything; redirects must be re-presented after the stall
                end else if (taken) begin
                    state_d = S_FLUSH;
                    pc_d    = tgt_i;
                    fcnt_d  = FLUSH_INIT;
                    vld_d   = 1'b0;
                    if (jcnt_q != 8'hFF) jcnt_d = jcnt_q + 8'd1;
                end else begin
                    pc_d  = pc_q + 1'b1;
                    vld_d = 1'b1;
                end
            end
            S_FLUSH: begin
                // target is read in the last bubble so it lands as the window closes
                imem_rd_o = (fcnt_q == 3'd1);
                if (fcnt_q == 3'd1) begin
                    state_d = S_RUN;
                    pc_d    = pc_q + 1'b1;
                    vld_d   = 1'b1;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                    vld_d  = 1'b0;
                end
            end
            S_HALT: begin
                vld_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_adr_o  = pc_q;
    assign instr_vld_o = vld_q;
    assign flush_o     = (state_q == S_FLUSH);
    assign halt_o      = (state_q == S_HALT);
    assign busy_o      = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign jmp_cnt_o   = jcnt_q;

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model of the sequencer.
module tb_pc_seq;

    localparam int PC_W      = 12;
    localparam int FLUSH_CYC = 2;
    localparam int START     = 0;

    logic            clk_i = 1'b0;
    logic            rst = 1'b0, start_i = 1'b0, stall_i = 1'b0;
    logic            jmp_i = 1'b0, jn_i = 1'b0, jr_i = 1'b0, cond_i = 1'b0, end_i = 1'b0;
    logic [PC_W-1:0] tgt_i = '0;
    logic [PC_W-1:0] imem_adr_o;
    logic            imem_rd_o, instr_vld_o, flush_o, halt_o, busy_o;
    logic [7:0]      jmp_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    pc_seq #(.PC_W(PC_W), .START_ADR(12'(START)), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk_i(clk_i), .rst(rst), .start_i(start_i), .stall_i(stall_i),
        .jmp_i(jmp_i), .jn_i(jn_i), .jr_i(jr_i), .cond_i(cond_i), .tgt_i(tgt_i),
        .end_i(end_i), .imem_adr_o(imem_adr_o), .imem_rd_o(imem_rd_o),
        .instr_vld_o(instr_vld_o), .flush_o(flush_o), .halt_o(halt_o),
        .busy_o(busy_o), .jmp_cnt_o(jmp_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // model: mode "idle"/"run"/"flush"/"halt", bubbles still to go, plain integers
    string m_mode = "idle";
    int    m_left = 0;
    int    m_pc   = START;
    int    m_vld  = 0;
    int    m_jumps = 0;
    bit    checking = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit tk;
        tk = jmp_i | ((jn_i | jr_i) & cond_i);
        if (rst) begin
            m_mode = "idle"; m_pc = START; m_left = 0; m_vld = 0; m_jumps = 0;
        end else if (m_mode == "idle") begin
            if (start_i) m_mode = "run";
        end else if (m_mode == "run") begin
            if (end_i) begin
                m_mode = "halt"; m_vld = 0;
            end else if (!stall_i) begin
                if (tk) begin
                    m_mode = "flush"; m_pc = int'(tgt_i); m_left = FLUSH_CYC; m_vld = 0;
                    m_jumps = (m_jumps < 255) ? m_jumps + 1 : 255;
                end else begin
                    m_pc = (m_pc + 1) % (1 << PC_W); m_vld = 1;
                end
            end
        end else if (m_mode == "flush") begin
            m_left--;
            if (m_left == 0) begin
                m_mode = "run"; m_pc = (m_pc + 1) % (1 << PC_W); m_vld = 1;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit s, input bit st, input bit j, input bit jn,
                         input bit jr, input bit c, input int t, input bit e);
        @(negedge clk_i);
        rst = r; start_i = s; stall_i = st; jmp_i = j; jn_i = jn; jr_i = jr;
        cond_i = c; tgt_i = PC_W'(t); end_i = e;
        #1;
        if (checking) begin
            chk("adr",   32'(imem_adr_o),  32'(m_pc));
            chk("rd",    32'(imem_rd_o),   32'((m_mode == "run" && !stall_i) || (m_mode == "flush" && m_left == 1)));
            chk("vld",   32'(instr_vld_o), 32'(m_vld));
            chk("flush", 32'(flush_o),     32'(m_mode == "flush"));
            chk("halt",  32'(halt_o),      32'(m_mode == "halt"));
            chk("busy",  32'(busy_o),      32'(m_mode == "run" || m_mode == "flush"));
            chk("jcnt",  32'(jmp_cnt_o),   32'(m_jumps));
        end
        @(posedge clk_i);
        model_step();
        if (r) checking = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle_cycles(5);                               // pc runs 0..5
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 0, 0, 1, 77, 0);
        idle_cycles(1);
        cycle(0, 0, 0, 1, 0, 0, 0, 12'h040, 0);       // taken JMP
        idle_cycles(4);
        cycle(0, 0, 0, 0, 1, 0, 0, 12'h300, 0);       // JN not taken
        cycle(0, 0, 0, 0, 0, 1, 1, 12'h123, 0);       // JR taken
        cycle(0, 0, 0, 1, 0, 0, 0, 12'h555, 0);       // ignored in FLUSH
        cycle(0, 0, 1, 0, 0, 0, 0, 0, 1);             // stall/end ignored in FLUSH
        idle_cycles(3);
        cycle(0, 0, 0, 1, 0, 0, 0, 12'hFFF, 0);       // wrap
        idle_cycles(5);
        for (int i = 0; i < 800; i++) cycle(0, 0, 0, 1, 0, 0, 0, i, 0);
        chk("jcnt_sat", 32'(jmp_cnt_o), 32'd255);
        idle_cycles(3);
        cycle(0, 0, 1, 1, 0, 0, 0, 12'h200, 1);       // end beats stall and jump
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 1, 0, 0, 0, 12'h010, 0);
        chk("halt_hold", 32'(halt_o), 32'd1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle_cycles(2);
        cycle(0, 0, 0, 1, 0, 0, 0, 12'h0AB, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);             // reset mid-FLUSH
        idle_cycles(2);

        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 63) == 0), $urandom_range(0, 1),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                  $urandom_range(0, 1), int'($urandom_range(0, 4095)),
                  ($urandom_range(0, 127) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
